// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: miss-wait state
// encoding, MUL occupancy bound and the stall-cause enum used by perf logic.
package pipe_ctrl_pkg;

  // Miss-wait FSM encoding, shared by the I-cache and D-cache instances.
  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mw_state_e;

  // Upper bound of MUL_LAT; the occupancy counter is sized from it.
  localparam int unsigned MulLatMax = 16;
  localparam int unsigned MulCntW   = $clog2(MulLatMax);

  // Highest-priority active stall in a cycle.
  typedef enum logic [2:0] {
    CauseNone = 3'd0,
    CauseMem  = 3'd1,
    CauseEx   = 3'd2,
    CauseId   = 3'd3,
    CauseIf   = 3'd4
  } stall_cause_e;

endpackage

// File: rtl/miss_wait_fsm.sv
// Two-state miss/wait tracker. Stalls combinationally on the cycle the miss is
// raised and keeps stalling until the fill-done pulse is sampled.
module miss_wait_fsm
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic miss,
  input  logic fill_done,
  input  logic force_idle,
  output logic stall
);

  mw_state_e state_q;

  // State update; force_idle wins so a redirect abandons an outstanding wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else if (force_idle) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (miss) state_q <= StWait;  // fill_done in idle is a stray pulse
        StWait: if (fill_done) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Zero-latency stall: the cycle that raises the miss already freezes.
  assign stall = ((state_q == StIdle) && miss) || (state_q == StWait);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core. Enable/flush outputs
// are combinational from inputs and state; oldest stage wins.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_hazard_stall,
  input  logic             ic_miss,
  input  logic             ic_fill_done,
  input  logic             dc_miss,
  input  logic             dc_fill_done,
  input  logic             ex_is_mul,
  input  logic             ex_branch_taken,
  input  logic             wb_exception,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] perf_mem_stall,
  output logic [CNT_W-1:0] perf_ex_stall,
  output logic [CNT_W-1:0] perf_id_stall,
  output logic [CNT_W-1:0] perf_if_stall
);

  localparam logic [MulCntW-1:0] MulLast = MulCntW'(MUL_LAT - 1);

  logic               mem_stall, ex_stall, id_stall, if_stall;
  logic [MulCntW-1:0] mul_cnt_q;

  miss_wait_fsm u_dc_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss       (dc_miss),
    .fill_done  (dc_fill_done),
    .force_idle (wb_exception),
    .stall      (mem_stall)
  );

  // I-cache wait survives redirects: the outstanding fill must still land.
  miss_wait_fsm u_ic_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss       (ic_miss),
    .fill_done  (ic_fill_done),
    .force_idle (1'b0),
    .stall      (if_stall)
  );

  assign ex_stall = ex_is_mul && (mul_cnt_q != MulLast);
  assign id_stall = id_hazard_stall;

  // MUL occupancy: counts only cycles without a MEM stall, clears on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt_q <= '0;
    end else if (wb_exception || !ex_is_mul) begin
      mul_cnt_q <= '0;
    end else if (!mem_stall) begin
      mul_cnt_q <= ex_stall ? mul_cnt_q + 1'b1 : '0;
    end
  end

  // Priority-resolved stage enables and bubble controls.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (wb_exception) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (id_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end else if (if_stall) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  stall_cause_e     cause;
  logic [CNT_W-1:0] perf_mem_q, perf_ex_q, perf_id_q, perf_if_q;

  // Same priority as the control decode; a taken branch masks ID/IF stalls.
  always_comb begin
    cause = CauseNone;
    if (wb_exception)         cause = CauseNone;
    else if (mem_stall)       cause = CauseMem;
    else if (ex_stall)        cause = CauseEx;
    else if (ex_branch_taken) cause = CauseNone;
    else if (id_stall)        cause = CauseId;
    else if (if_stall)        cause = CauseIf;
  end

  // Saturating stall-cycle counters, one per cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_mem_q <= '0;
      perf_ex_q  <= '0;
      perf_id_q  <= '0;
      perf_if_q  <= '0;
    end else begin
      if (cause == CauseMem && perf_mem_q != '1) perf_mem_q <= perf_mem_q + 1'b1;
      if (cause == CauseEx  && perf_ex_q  != '1) perf_ex_q  <= perf_ex_q + 1'b1;
      if (cause == CauseId  && perf_id_q  != '1) perf_id_q  <= perf_id_q + 1'b1;
      if (cause == CauseIf  && perf_if_q  != '1) perf_if_q  <= perf_if_q + 1'b1;
    end
  end

  assign perf_mem_stall = perf_mem_q;
  assign perf_ex_stall  = perf_ex_q;
  assign perf_id_stall  = perf_id_q;
  assign perf_if_stall  = perf_if_q;
`else
  assign perf_mem_stall = '0;
  assign perf_ex_stall  = '0;
  assign perf_id_stall  = '0;
  assign perf_if_stall  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control words are queued as each
// step is driven and popped when the combinational outputs are sampled.
module tb_pipe_ctrl;

  localparam int unsigned CntW = 32;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  // Input bits: {wb_exception, ex_branch_taken, ex_is_mul, dc_fill_done,
  //              dc_miss, ic_fill_done, ic_miss, id_hazard_stall}
  localparam logic [7:0] IHaz = 8'h01, IIcm = 8'h02, IIcf = 8'h04, IDcm = 8'h08;
  localparam logic [7:0] IDcf = 8'h10, IMul = 8'h20, IBr  = 8'h40, IExc = 8'h80;

  // Control word: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem,mem_wb flushes}
  localparam logic [8:0] CtlRun = 9'b11111_0000;
  localparam logic [8:0] CtlMem = 9'b00001_0001;
  localparam logic [8:0] CtlEx  = 9'b00011_0010;
  localparam logic [8:0] CtlBr  = 9'b11111_1100;
  localparam logic [8:0] CtlId  = 9'b00111_0100;
  localparam logic [8:0] CtlIf  = 9'b01111_1000;
  localparam logic [8:0] CtlExc = 9'b11111_1111;

  logic clk = 1'b0;
  logic rst_n;
  logic id_hazard_stall, ic_miss, ic_fill_done, dc_miss, dc_fill_done;
  logic ex_is_mul, ex_branch_taken, wb_exception;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [CntW-1:0] perf_mem_stall, perf_ex_stall, perf_id_stall, perf_if_stall;
  logic [8:0] ctl_obs;

  typedef struct {
    string      tag;
    logic [8:0] ctl;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .MUL_LAT (4),
    .CNT_W   (CntW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_hazard_stall (id_hazard_stall),
    .ic_miss         (ic_miss),
    .ic_fill_done    (ic_fill_done),
    .dc_miss         (dc_miss),
    .dc_fill_done    (dc_fill_done),
    .ex_is_mul       (ex_is_mul),
    .ex_branch_taken (ex_branch_taken),
    .wb_exception    (wb_exception),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .mem_wb_flush    (mem_wb_flush),
    .perf_mem_stall  (perf_mem_stall),
    .perf_ex_stall   (perf_ex_stall),
    .perf_id_stall   (perf_id_stall),
    .perf_if_stall   (perf_if_stall)
  );

  assign ctl_obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  task automatic drive(input logic [7:0] v);
    {wb_exception, ex_branch_taken, ex_is_mul, dc_fill_done,
     dc_miss, ic_fill_done, ic_miss, id_hazard_stall} = v;
  endtask

  task automatic check_ctl(input string tag, input logic [8:0] exp_ctl);
    n_checks++;
    assert (ctl_obs === exp_ctl)
    else begin
      n_fail++;
      $error("FAIL %s: ctl=%b expected %b", tag, ctl_obs, exp_ctl);
    end
  endtask

  // One clock cycle: entered just after a rising edge, leaves just after the next.
  task automatic step(input string tag, input logic [7:0] v, input logic [8:0] exp_ctl);
    exp_t e;
    exp_t got;
    drive(v);
    e.tag = tag;
    e.ctl = exp_ctl;
    sb.push_back(e);
    #3;
    got = sb.pop_front();
    check_ctl(got.tag, got.ctl);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [CntW-1:0] obs,
                           input logic [CntW-1:0] exp_full);
    logic [CntW-1:0] exp_v;
    exp_v = PerfEn ? exp_full : '0;
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: count=%0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_perf(input string tag, input int m, input int e, input int d,
                            input int f);
    check_cnt({tag, "_mem"}, perf_mem_stall, CntW'(m));
    check_cnt({tag, "_ex"},  perf_ex_stall,  CntW'(e));
    check_cnt({tag, "_id"},  perf_id_stall,  CntW'(d));
    check_cnt({tag, "_if"},  perf_if_stall,  CntW'(f));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00);
    #2;
    check_ctl("reset_ctl", CtlRun);
    check_perf("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("idle", 8'h00, CtlRun);

    // D-cache miss, four wait cycles including the fill-done cycle.
    step("dc_miss",   IDcm,  CtlMem);
    step("dc_wait1",  8'h00, CtlMem);
    step("dc_wait2",  8'h00, CtlMem);
    step("dc_wait3",  8'h00, CtlMem);
    step("dc_fill",   IDcf,  CtlMem);
    step("dc_replay", 8'h00, CtlRun);
    check_perf("after_dc", 5, 0, 0, 0);

    // MUL occupies EX for four cycles.
    step("mul_c0",  IMul,  CtlEx);
    step("mul_c1",  IMul,  CtlEx);
    step("mul_c2",  IMul,  CtlEx);
    step("mul_adv", IMul,  CtlRun);
    step("mul_gone", 8'h00, CtlRun);
    check_perf("after_mul", 5, 3, 0, 0);

    // Branch overrides a hazard stall; hazard alone stalls ID.
    step("br_haz", IBr | IHaz, CtlBr);
    check_perf("br_haz", 5, 3, 0, 0);
    step("haz", IHaz, CtlId);
    check_perf("haz", 5, 3, 1, 0);

    // I-cache miss with a redirect while waiting: wait persists.
    step("ic_miss",    IIcm,  CtlIf);
    step("ic_wait",    8'h00, CtlIf);
    step("ic_br",      IBr,   CtlBr);
    step("ic_wait2",   8'h00, CtlIf);
    step("ic_fill",    IIcf,  CtlIf);
    step("ic_done",    8'h00, CtlRun);
    check_perf("after_ic", 5, 3, 1, 4);

    // MUL interrupted by a D-cache miss: counter holds, occupancy 4 + 3.
    step("mm_c0",   IMul,        CtlEx);
    step("mm_miss", IMul | IDcm, CtlMem);
    step("mm_wait", IMul,        CtlMem);
    step("mm_fill", IMul | IDcf, CtlMem);
    step("mm_c1",   IMul,        CtlEx);
    step("mm_c2",   IMul,        CtlEx);
    step("mm_adv",  IMul,        CtlRun);
    step("mm_gone", 8'h00,       CtlRun);
    check_perf("after_mm", 8, 6, 1, 4);

    // Exception during D-cache wait returns the FSM to idle; stray fill ignored.
    step("ex_dmiss", IDcm,  CtlMem);
    step("ex_dwait", 8'h00, CtlMem);
    step("exc",      IExc,  CtlExc);
    step("exc_next", 8'h00, CtlRun);
    step("stray",    IDcf,  CtlRun);
    step("stray2",   8'h00, CtlRun);
    check_perf("after_exc", 10, 6, 1, 4);

    // Exception clears a partially counted MUL.
    step("xm_c0",  IMul,        CtlEx);
    step("xm_exc", IMul | IExc, CtlExc);
    step("xm_c0b", IMul,        CtlEx);
    step("xm_c1",  IMul,        CtlEx);
    step("xm_c2",  IMul,        CtlEx);
    step("xm_adv", IMul,        CtlRun);
    check_perf("after_xm", 10, 10, 1, 4);

    // Miss and fill-done together in idle: enter wait, pulse ignored.
    step("both",   IDcm | IDcf, CtlMem);
    step("both_w", 8'h00,       CtlMem);
    step("both_f", IDcf,        CtlMem);
    step("both_r", 8'h00,       CtlRun);
    check_perf("after_both", 13, 10, 1, 4);

    // Asynchronous reset mid I-cache wait.
    step("ar_miss", IIcm,  CtlIf);
    step("ar_wait", 8'h00, CtlIf);
    #1;
    rst_n = 1'b0;
    #1;
    check_ctl("async_rst_ctl", CtlRun);
    check_perf("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst", 8'h00, CtlRun);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
